lfsr_scheduler: RTL and testbench

Round-robin scheduler that shares one 8-bit XNOR-feedback LFSR among NREQ requesters. On each grant it advances the LFSR a fixed number of steps, then hands the winner one fresh byte with a one-cycle valid/grant pulse. It also owns seeding of the generator. It sits between the PRBS datapath and its consumers, for example scramblers and test-pattern sources.

---
 rtl/lfsr_sched_pkg.sv | 26 ++
 rtl/lfsr_core.sv | 25 ++
 rtl/lfsr_scheduler.sv | 118 +++++++++++
 tb/tb_lfsr_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_sched_pkg.sv
// Shared types, constants and LFSR step function for the LFSR scheduler.
// Contents: FSM state enum, LFSR width/reset value, feedback taps, lfsr_step().
package lfsr_sched_pkg;

  localparam int unsigned LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_RST = 8'h00;

  // Feedback taps of the 8-bit XNOR LFSR.
  localparam int unsigned TAP_A = 7;
  localparam int unsigned TAP_B = 5;
  localparam int unsigned TAP_C = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DELIVER = 2'd2
  } state_t;

  // One XNOR-feedback shift; 0x00 is a legal state for XNOR feedback.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
    logic tap;
    tap = ~(q[TAP_A] ^ q[TAP_B] ^ q[TAP_C]);
    return {q[LFSR_W-2:0], tap};
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// 8-bit XNOR-feedback LFSR register with seed load.
// Ports: clk, rst (async active-low), en (shift one step), load (q <= din,
// wins over en), din seed value, q current LFSR state.
module lfsr_core
  import lfsr_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [LFSR_W-1:0] din,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= LFSR_RST;
    end else if (load) begin
      q <= din;
    end else if (en) begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/lfsr_scheduler.sv
// Round-robin scheduler sharing one LFSR among NREQ requesters. Each grant
// advances the LFSR STEPS times, then pulses gnt/rnd_valid for one cycle
// with the fresh byte on rnd_data.
// Ports: clk, rst (async active-low), req[NREQ] level requests,
// gnt[NREQ] one-hot grant pulse, rnd_valid, rnd_data[8], seed_load, seed[8],
// busy (high in RUN and DELIVER). All outputs are registered.
module lfsr_scheduler
  import lfsr_sched_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned STEPS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  output logic              rnd_valid,
  output logic [LFSR_W-1:0] rnd_data,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  output logic              busy
);

  localparam int unsigned PTR_W = $clog2(NREQ);
  localparam int unsigned CNT_W = $clog2(STEPS + 1);

  state_t             state_q;
  state_t             state_d;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   owner_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [PTR_W-1:0]   winner;
  logic               win_found;
  logic               start;
  logic [LFSR_W-1:0]  lfsr_q;

  // LFSR shifts only in RUN; seeding only accepted in IDLE.
  lfsr_core u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == RUN),
    .load ((state_q == IDLE) && seed_load),
    .din  (seed),
    .q    (lfsr_q)
  );

  // Round-robin search starting at ptr_q.
  always_comb begin
    int unsigned idx;
    win_found = 1'b0;
    winner    = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr_q) + i) % NREQ;
      if (!win_found && req[PTR_W'(idx)]) begin
        win_found = 1'b1;
        winner    = PTR_W'(idx);
      end
    end
  end

  // A grant starts only in IDLE and only when no seed load competes.
  assign start = (state_q == IDLE) && !seed_load && win_found;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == CNT_W'(STEPS - 1)) state_d = DELIVER;
      DELIVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counter, pointer and owner registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            owner_q <= winner;
            cnt_q   <= '0;
          end
        end
        RUN: cnt_q <= cnt_q + CNT_W'(1);
        DELIVER: begin
          if (owner_q == PTR_W'(NREQ - 1)) ptr_q <= '0;
          else                             ptr_q <= owner_q + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs registered from next state; the delivered byte is the LFSR value
  // after the final RUN shift, i.e. one step beyond the current q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt       <= '0;
      rnd_valid <= 1'b0;
      rnd_data  <= LFSR_RST;
      busy      <= 1'b0;
    end else begin
      busy      <= (state_d != IDLE);
      rnd_valid <= (state_d == DELIVER);
      gnt       <= (state_d == DELIVER) ? (NREQ'(1) << owner_q) : '0;
      rnd_data  <= (state_d == DELIVER) ? lfsr_step(lfsr_q) : '0;
    end
  end

endmodule

// File: tb/tb_lfsr_scheduler.sv
// Directed bench for lfsr_scheduler with a scoreboard of expected grants.
module tb_lfsr_scheduler;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned STEPS = 8;

  typedef struct packed {
    logic [3:0] g;
    logic [7:0] d;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       rnd_valid;
  logic [7:0] rnd_data;
  logic       seed_load;
  logic [7:0] seed;
  logic       busy;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  int         idle_seen = 0;
  int         n;
  logic       got_valid;
  logic [7:0] mq;

  lfsr_scheduler #(.NREQ(NREQ), .STEPS(STEPS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .rnd_valid (rnd_valid),
    .rnd_data  (rnd_data),
    .seed_load (seed_load),
    .seed      (seed),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mstep(input logic [7:0] q);
    logic fb;
    fb = ~(q[7] ^ q[5] ^ q[4]);
    return {q[6:0], fb};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_grant(input logic [3:0] g);
    exp_t e;
    for (int i = 0; i < int'(STEPS); i++) mq = mstep(mq);
    e.g = g;
    e.d = mq;
    sb.push_back(e);
  endtask

  // One clock; sample outputs just after the edge and score any delivery.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    got_valid = rnd_valid;
    if (!busy) idle_seen++;
    if (rnd_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_grant", {20'h0, gnt, rnd_data}, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("gnt", {28'h0, gnt}, {28'h0, e.g});
        chk("rnd_data", {24'h0, rnd_data}, {24'h0, e.d});
        chk("gnt_onehot", {31'h0, $onehot(gnt)}, 32'h1);
      end
    end else begin
      chk("quiet_gnt", {28'h0, gnt}, 32'h0);
      chk("quiet_data", {24'h0, rnd_data}, 32'h0);
    end
  endtask

  task automatic wait_valid(input int maxc, output int cyc);
    cyc = 0;
    got_valid = 1'b0;
    while (!got_valid && cyc < maxc) begin
      tick();
      cyc++;
    end
    chk("valid_timeout", {31'h0, got_valid}, 32'h1);
  endtask

  initial begin
    rst = 1'b0;
    req = '0;
    seed_load = 1'b0;
    seed = '0;
    mq = 8'h00;

    // Reset state.
    #12;
    chk("rst_gnt", {28'h0, gnt}, 32'h0);
    chk("rst_valid", {31'h0, rnd_valid}, 32'h0);
    chk("rst_data", {24'h0, rnd_data}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    rst = 1'b1;
    tick();

    // Single requester, two bytes back to back.
    req = 4'b0001;
    push_grant(4'b0001);
    wait_valid(20, n);
    chk("lat_first", n, 9);
    chk("byte_fb", {24'h0, rnd_data}, 32'hFB);
    push_grant(4'b0001);
    wait_valid(20, n);
    chk("lat_second", n, 10);
    chk("byte_31", {24'h0, rnd_data}, 32'h31);
    req = '0;
    tick();
    tick();
    chk("idle_busy", {31'h0, busy}, 32'h0);

    // Seed then request.
    seed = 8'h0F;
    seed_load = 1'b1;
    mq = 8'h0F;
    tick();
    seed_load = 1'b0;
    chk("seed_busy", {31'h0, busy}, 32'h0);
    req = 4'b0001;
    push_grant(4'b0001);
    wait_valid(20, n);
    chk("seed_lat", n, 9);
    chk("byte_b3", {24'h0, rnd_data}, 32'hB3);
    req = '0;
    tick();

    // Seed and request together: seed wins, grant one cycle later.
    seed = 8'h0F;
    seed_load = 1'b1;
    req = 4'b0001;
    mq = 8'h0F;
    push_grant(4'b0001);
    tick();
    chk("seed_prio_busy", {31'h0, busy}, 32'h0);
    seed_load = 1'b0;
    wait_valid(20, n);
    chk("seed_prio_lat", n, 9);
    chk("seed_prio_byte", {24'h0, rnd_data}, 32'hB3);
    req = '0;
    tick();

    // Reset, then all requesters held: rotation 0,1,2,3,0.
    rst = 1'b0;
    #2;
    rst = 1'b1;
    mq = 8'h00;
    req = 4'b1111;
    push_grant(4'b0001);
    push_grant(4'b0010);
    push_grant(4'b0100);
    push_grant(4'b1000);
    push_grant(4'b0001);
    for (int k = 0; k < 5; k++) begin
      idle_seen = 0;
      wait_valid(20, n);
      chk("rr_lat", n, (k == 0) ? 9 : 10);
      chk("rr_idle_cycles", idle_seen, (k == 0) ? 0 : 1);
    end
    req = '0;
    tick();
    tick();

    // Requester 2 alone, dropped during RUN: grant still delivered.
    req = 4'b0100;
    push_grant(4'b0100);
    tick();
    tick();
    tick();
    chk("drop_busy_run", {31'h0, busy}, 32'h1);
    req = '0;
    wait_valid(20, n);
    chk("drop_lat", n, 6);
    chk("drop_gnt", {28'h0, gnt}, 32'h4);
    tick();
    chk("drop_busy_after", {31'h0, busy}, 32'h0);
    chk("drop_valid_after", {31'h0, rnd_valid}, 32'h0);

    // Reset mid-RUN: outputs clear without a clock, grant lost.
    req = 4'b0001;
    tick();
    tick();
    tick();
    tick();
    chk("mid_busy", {31'h0, busy}, 32'h1);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_gnt", {28'h0, gnt}, 32'h0);
    chk("mid_rst_valid", {31'h0, rnd_valid}, 32'h0);
    chk("mid_rst_data", {24'h0, rnd_data}, 32'h0);
    req = '0;
    #1;
    rst = 1'b1;
    mq = 8'h00;
    tick();
    req = 4'b0001;
    push_grant(4'b0001);
    wait_valid(20, n);
    chk("post_rst_lat", n, 9);
    chk("post_rst_byte", {24'h0, rnd_data}, 32'hFB);
    req = '0;
    tick();

    // seed_load during RUN is ignored.
    req = 4'b0001;
    push_grant(4'b0001);
    tick();
    tick();
    seed = 8'h55;
    seed_load = 1'b1;
    tick();
    tick();
    seed_load = 1'b0;
    wait_valid(20, n);
    chk("seed_run_lat", n, 5);
    chk("seed_run_byte", {24'h0, rnd_data}, 32'h31);
    req = '0;
    tick();
    tick();

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
